// File: rtl/jpc_regfile_arb_pkg.sv
// Shared definitions for the jpc_regfile port arbiter: data width, FSM states
// and client identifiers.
package jpc_regfile_arb_pkg;

  localparam int unsigned JPC_REGDATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    CLI_WB  = 2'd0,
    CLI_RD1 = 2'd1,
    CLI_RD2 = 2'd2
  } client_e;

endpackage

// File: rtl/jpc_regfile_arb_pick.sv
// Combinational winner selection among writeback, rd1 and rd2.
// Writeback wins unless the read side is being starved; reads alternate by pointer.
module jpc_regfile_arb_pick
  import jpc_regfile_arb_pkg::*;
(
  input  logic       wb_valid,
  input  logic       rd1_valid,
  input  logic       rd2_valid,
  input  logic       rr_rd2,
  input  logic       starve,
  output logic       grant,
  output logic [1:0] client
);

  logic read_pending;

  always_comb begin
    read_pending = rd1_valid | rd2_valid;
    grant        = wb_valid | read_pending;
    client       = CLI_WB;
    if (wb_valid && !(starve && read_pending)) begin
      client = CLI_WB;
    end else if (rd1_valid && (!rd2_valid || !rr_rd2)) begin
      client = CLI_RD1;
    end else if (rd2_valid) begin
      client = CLI_RD2;
    end
  end

endmodule

// File: rtl/jpc_regfile_arb.sv
// Sequencer sharing one jpc_regfile port between writeback and two operand reads.
// Register 0 is resolved locally; all register-file outputs come from latched state.
module jpc_regfile_arb
  import jpc_regfile_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   wb_idx_I,
  input  logic [JPC_REGDATA_WIDTH-1:0] wb_wdata_I,
  input  logic                         wb_valid_I,
  output logic                         wb_done_O,
  input  logic [4:0]                   rd1_idx_I,
  input  logic [4:0]                   rd2_idx_I,
  input  logic                         rd1_valid_I,
  input  logic                         rd2_valid_I,
  output logic [JPC_REGDATA_WIDTH-1:0] rd1_data_O,
  output logic [JPC_REGDATA_WIDTH-1:0] rd2_data_O,
  output logic                         rd1_data_valid_O,
  output logic                         rd2_data_valid_O,
  output logic                         rf_idx_op_O,
  output logic [4:0]                   rf_idx_O,
  output logic                         rf_idx_valid_O,
  input  logic                         rf_idx_ready_I,
  output logic [JPC_REGDATA_WIDTH-1:0] rf_wdata_O,
  output logic                         rf_wdata_valid_O,
  input  logic                         rf_wdata_ready_I,
  output logic                         rf_rdata_ready_O,
  input  logic [JPC_REGDATA_WIDTH-1:0] rf_rdata_I,
  input  logic                         rf_rdata_valid_I
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  arb_state_e                   state_q, state_d;
  client_e                      client_q, client_d;
  logic [4:0]                   idx_q, idx_d;
  logic [JPC_REGDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                         op_q, op_d;
  logic                         idx_valid_q, idx_valid_d;
  logic                         wdata_valid_q, wdata_valid_d;
  logic                         rdata_ready_q, rdata_ready_d;
  logic                         idx_done_q, idx_done_d;
  logic                         wd_done_q, wd_done_d;
  logic [3:0]                   streak_q, streak_d;
  logic                         rr_rd2_q, rr_rd2_d;
  logic                         wb_done_q, wb_done_d;
  logic                         rd1_dv_q, rd1_dv_d;
  logic                         rd2_dv_q, rd2_dv_d;
  logic [JPC_REGDATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic [JPC_REGDATA_WIDTH-1:0] rd2_data_q, rd2_data_d;

  logic       grant;
  logic [1:0] grant_client;
  logic [4:0] grant_idx;
  logic       read_pending;
  logic       idx_hs;
  logic       wd_hs;

  jpc_regfile_arb_pick u_pick (
    .wb_valid  (wb_valid_I),
    .rd1_valid (rd1_valid_I),
    .rd2_valid (rd2_valid_I),
    .rr_rd2    (rr_rd2_q),
    .starve    (streak_q == STREAK_MAX),
    .grant     (grant),
    .client    (grant_client)
  );

  always_comb begin
    state_d       = state_q;
    client_d      = client_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    op_d          = op_q;
    idx_valid_d   = idx_valid_q;
    wdata_valid_d = wdata_valid_q;
    rdata_ready_d = rdata_ready_q;
    idx_done_d    = idx_done_q;
    wd_done_d     = wd_done_q;
    streak_d      = streak_q;
    rr_rd2_d      = rr_rd2_q;
    rd1_data_d    = rd1_data_q;
    rd2_data_d    = rd2_data_q;
    wb_done_d     = 1'b0;
    rd1_dv_d      = 1'b0;
    rd2_dv_d      = 1'b0;

    read_pending = rd1_valid_I | rd2_valid_I;
    idx_hs       = idx_valid_q & rf_idx_ready_I;
    wd_hs        = wdata_valid_q & rf_wdata_ready_I;
    case (grant_client)
      CLI_RD1: grant_idx = rd1_idx_I;
      CLI_RD2: grant_idx = rd2_idx_I;
      default: grant_idx = wb_idx_I;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        idx_done_d = 1'b0;
        wd_done_d  = 1'b0;
        if (!read_pending) streak_d = '0;
        if (grant) begin
          client_d = client_e'(grant_client);
          op_d     = (grant_client == CLI_WB);
          idx_d    = grant_idx;
          wdata_d  = wb_wdata_I;
          if (grant_client == CLI_WB) begin
            if (read_pending && streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
          end else begin
            streak_d = '0;
            rr_rd2_d = (grant_client == CLI_RD1);
          end
          // Register 0 never reaches the register file: writes vanish, reads return zero.
          if (grant_idx == '0) begin
            state_d = ST_DONE;
            case (grant_client)
              CLI_RD1: begin rd1_dv_d = 1'b1; rd1_data_d = '0; end
              CLI_RD2: begin rd2_dv_d = 1'b1; rd2_data_d = '0; end
              default: wb_done_d = 1'b1;
            endcase
          end else begin
            state_d       = ST_REQ;
            idx_valid_d   = 1'b1;
            wdata_valid_d = (grant_client == CLI_WB);
          end
        end
      end
      ST_REQ: begin
        if (idx_hs) idx_valid_d = 1'b0;
        if (wd_hs) wdata_valid_d = 1'b0;
        if (op_q) begin
          idx_done_d = idx_done_q | idx_hs;
          wd_done_d  = wd_done_q | wd_hs;
          if (idx_done_d && wd_done_d) begin
            state_d   = ST_DONE;
            wb_done_d = 1'b1;
          end
        end else if (idx_hs) begin
          state_d       = ST_RESP;
          rdata_ready_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rf_rdata_valid_I) begin
          state_d       = ST_DONE;
          rdata_ready_d = 1'b0;
          if (client_q == CLI_RD2) begin
            rd2_dv_d   = 1'b1;
            rd2_data_d = rf_rdata_I;
          end else begin
            rd1_dv_d   = 1'b1;
            rd1_data_d = rf_rdata_I;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      client_q      <= CLI_WB;
      idx_q         <= '0;
      wdata_q       <= '0;
      op_q          <= 1'b0;
      idx_valid_q   <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      idx_done_q    <= 1'b0;
      wd_done_q     <= 1'b0;
      streak_q      <= '0;
      rr_rd2_q      <= 1'b0;
      wb_done_q     <= 1'b0;
      rd1_dv_q      <= 1'b0;
      rd2_dv_q      <= 1'b0;
      rd1_data_q    <= '0;
      rd2_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      client_q      <= client_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      op_q          <= op_d;
      idx_valid_q   <= idx_valid_d;
      wdata_valid_q <= wdata_valid_d;
      rdata_ready_q <= rdata_ready_d;
      idx_done_q    <= idx_done_d;
      wd_done_q     <= wd_done_d;
      streak_q      <= streak_d;
      rr_rd2_q      <= rr_rd2_d;
      wb_done_q     <= wb_done_d;
      rd1_dv_q      <= rd1_dv_d;
      rd2_dv_q      <= rd2_dv_d;
      rd1_data_q    <= rd1_data_d;
      rd2_data_q    <= rd2_data_d;
    end
  end

  assign wb_done_O        = wb_done_q;
  assign rd1_data_valid_O = rd1_dv_q;
  assign rd2_data_valid_O = rd2_dv_q;
  assign rd1_data_O       = rd1_data_q;
  assign rd2_data_O       = rd2_data_q;
  assign rf_idx_op_O      = op_q;
  assign rf_idx_O         = idx_q;
  assign rf_idx_valid_O   = idx_valid_q;
  assign rf_wdata_O       = wdata_q;
  assign rf_wdata_valid_O = wdata_valid_q;
  assign rf_rdata_ready_O = rdata_ready_q;

endmodule

// File: tb/tb_jpc_regfile_arb.sv
// Bench for jpc_regfile_arb: register-file responder, transaction-level shadow
// model with expected grant order, and directed latency/boundary vectors.
module tb_jpc_regfile_arb;
  import jpc_regfile_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_idx_I, rd1_idx_I, rd2_idx_I;
  logic [31:0] wb_wdata_I;
  logic        wb_valid_I, rd1_valid_I, rd2_valid_I;
  logic        wb_done_O, rd1_data_valid_O, rd2_data_valid_O;
  logic [31:0] rd1_data_O, rd2_data_O;
  logic        rf_idx_op_O, rf_idx_valid_O, rf_idx_ready_I;
  logic [4:0]  rf_idx_O;
  logic [31:0] rf_wdata_O, rf_rdata_I;
  logic        rf_wdata_valid_O, rf_wdata_ready_I, rf_rdata_ready_O, rf_rdata_valid_I;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] shadow [32];
  int          exp_order [$];
  logic        rf_seen;

  logic [31:0] rf_mem [32];
  logic        mem_init = 1'b0;
  logic        rd_pend = 1'b0, got_i = 1'b0, got_d = 1'b0, rdata_hold = 1'b0;
  logic [4:0]  rd_idx = '0, wr_idx = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  jpc_regfile_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_idx_I(wb_idx_I), .wb_wdata_I(wb_wdata_I), .wb_valid_I(wb_valid_I), .wb_done_O(wb_done_O),
    .rd1_idx_I(rd1_idx_I), .rd2_idx_I(rd2_idx_I),
    .rd1_valid_I(rd1_valid_I), .rd2_valid_I(rd2_valid_I),
    .rd1_data_O(rd1_data_O), .rd2_data_O(rd2_data_O),
    .rd1_data_valid_O(rd1_data_valid_O), .rd2_data_valid_O(rd2_data_valid_O),
    .rf_idx_op_O(rf_idx_op_O), .rf_idx_O(rf_idx_O), .rf_idx_valid_O(rf_idx_valid_O),
    .rf_idx_ready_I(rf_idx_ready_I), .rf_wdata_O(rf_wdata_O), .rf_wdata_valid_O(rf_wdata_valid_O),
    .rf_wdata_ready_I(rf_wdata_ready_I), .rf_rdata_ready_O(rf_rdata_ready_O),
    .rf_rdata_I(rf_rdata_I), .rf_rdata_valid_I(rf_rdata_valid_I)
  );

  // Register-file responder: handshakes are noted mid-cycle, responses driven just after the edge.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      mem_init = 1'b1;
    end
    if (rst) begin
      rd_pend = 1'b0; got_i = 1'b0; got_d = 1'b0;
    end else begin
      if (rf_rdata_valid_I && rf_rdata_ready_O) rd_pend = 1'b0;
      if (rf_idx_valid_O && rf_idx_ready_I) begin
        if (rf_idx_op_O) begin wr_idx = rf_idx_O; got_i = 1'b1; end
        else begin rd_idx = rf_idx_O; rd_pend = 1'b1; end
      end
      if (rf_wdata_valid_O && rf_wdata_ready_I) begin wr_data = rf_wdata_O; got_d = 1'b1; end
      if (got_i && got_d) begin rf_mem[wr_idx] = wr_data; got_i = 1'b0; got_d = 1'b0; end
    end
  end

  always @(posedge clk) begin
    #1;
    rf_rdata_valid_I = rf_rdata_ready_O && rd_pend && !rdata_hold;
    rf_rdata_I       = rd_pend ? rf_mem[rd_idx] : '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic pulse_of(input int which);
    case (which)
      0:       return wb_done_O;
      1:       return rd1_data_valid_O;
      default: return rd2_data_valid_O;
    endcase
  endfunction

  task automatic set_valid(input int which, input logic v);
    case (which)
      0:       wb_valid_I = v;
      1:       rd1_valid_I = v;
      default: rd2_valid_I = v;
    endcase
  endtask

  // Issue one request at the current IDLE cycle (cycle 0), wait for its pulse, then release it.
  task automatic run_tx(input int which, input logic [4:0] idx, input logic [31:0] data,
                        input int exp_lat, input string nm);
    int lat = -1;
    logic [31:0] got = '0;
    exp_order.push_back(which);
    case (which)
      0:       begin wb_idx_I = idx; wb_wdata_I = data; end
      1:       rd1_idx_I = idx;
      default: rd2_idx_I = idx;
    endcase
    set_valid(which, 1'b1);
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (pulse_of(which)) begin
        lat = n;
        got = (which == 2) ? rd2_data_O : rd1_data_O;
      end
      @(posedge clk); #1;
    end
    set_valid(which, 1'b0);
    chk({nm, "_latency"}, lat, exp_lat);
    if (which != 0) chk({nm, "_data"}, got, data);
  endtask

  initial begin
    int seq [6];
    int cnt;
    int lat;
    logic [31:0] rd_got;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst = 1'b1;
    wb_idx_I = '0; wb_wdata_I = '0; wb_valid_I = 1'b0;
    rd1_idx_I = '0; rd2_idx_I = '0; rd1_valid_I = 1'b0; rd2_valid_I = 1'b0;
    rf_idx_ready_I = 1'b1; rf_wdata_ready_I = 1'b1;
    rf_seen = 1'b0;

    fork
      forever begin
        int npulse, who, exp_who;
        logic [4:0] ridx;
        @(negedge clk);
        if (rf_idx_valid_O || rf_wdata_valid_O || rf_rdata_ready_O) rf_seen = 1'b1;
        if (rf_idx_valid_O) chk("rf_idx_nonzero", 32'(rf_idx_O != 5'd0), 32'd1);
        npulse = int'(wb_done_O) + int'(rd1_data_valid_O) + int'(rd2_data_valid_O);
        if (npulse != 0) begin
          chk("single_pulse", npulse, 1);
          who = wb_done_O ? 0 : (rd1_data_valid_O ? 1 : 2);
          exp_who = (exp_order.size() > 0) ? exp_order.pop_front() : 3;
          chk("grant_order", who, exp_who);
          if (who == 0) begin
            if (wb_idx_I != 5'd0) shadow[wb_idx_I] = wb_wdata_I;
          end else begin
            ridx = (who == 1) ? rd1_idx_I : rd2_idx_I;
            chk("model_read_data", (who == 1) ? rd1_data_O : rd2_data_O, shadow[ridx]);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {rf_idx_valid_O, rf_wdata_valid_O, rf_rdata_ready_O, rf_idx_op_O,
                        wb_done_O, rd1_data_valid_O, rd2_data_valid_O, rf_idx_O}, 32'd0);
    chk("reset_rd1_data", rd1_data_O, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back through the register file.
    run_tx(0, 5'd7, 32'hDEADBEEF, 2, "wb7");
    run_tx(1, 5'd7, 32'hDEADBEEF, 3, "rd1_7");

    // Register 0 stays local.
    rf_seen = 1'b0;
    run_tx(0, 5'd0, 32'h12345678, 1, "wb0");
    run_tx(2, 5'd0, 32'h0, 1, "rd2_0");
    chk("r0_no_rf_activity", 32'(rf_seen), 32'd0);

    // Round-robin with both readers always requesting.
    run_tx(0, 5'd3, 32'h0000_0033, 2, "wb3");
    run_tx(0, 5'd5, 32'h0000_0055, 2, "wb5");
    exp_order.push_back(1); exp_order.push_back(2);
    exp_order.push_back(1); exp_order.push_back(2);
    rd1_idx_I = 5'd3; rd2_idx_I = 5'd5; rd1_valid_I = 1'b1; rd2_valid_I = 1'b1;
    cnt = 0;
    for (int n = 0; n < 60 && cnt < 4; n++) begin
      @(negedge clk);
      if (rd1_data_valid_O || rd2_data_valid_O) begin
        seq[cnt] = rd1_data_valid_O ? 1 : 2;
        cnt++;
      end
      @(posedge clk); #1;
    end
    rd1_valid_I = 1'b0; rd2_valid_I = 1'b0;
    chk("rr_count", cnt, 4);
    chk("rr_0", seq[0], 1); chk("rr_1", seq[1], 2);
    chk("rr_2", seq[2], 1); chk("rr_3", seq[3], 2);

    // Starvation: wb always valid, rd1 held until served.
    foreach (seq[i]) seq[i] = -1;
    for (int i = 0; i < 4; i++) exp_order.push_back(0);
    exp_order.push_back(1); exp_order.push_back(0);
    wb_idx_I = 5'd9; wb_wdata_I = 32'h0000_0099; rd1_idx_I = 5'd9;
    wb_valid_I = 1'b1; rd1_valid_I = 1'b1;
    cnt = 0; rd_got = '0;
    for (int n = 0; n < 100 && cnt < 6; n++) begin
      @(negedge clk);
      if (wb_done_O || rd1_data_valid_O) begin
        seq[cnt] = rd1_data_valid_O ? 1 : 0;
        if (rd1_data_valid_O) rd_got = rd1_data_O;
        cnt++;
      end
      @(posedge clk); #1;
      if (cnt > 0 && seq[cnt-1] == 1) rd1_valid_I = 1'b0;
    end
    wb_valid_I = 1'b0; rd1_valid_I = 1'b0;
    chk("starve_count", cnt, 6);
    chk("starve_seq", {28'd0, 4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3]), 4'(seq[4]), 4'(seq[5])} >> 0,
        32'h0000_0010);
    chk("starve_rd_data", rd_got, 32'h0000_0099);

    // Split write handshake: wdata ready withheld until cycle 4.
    exp_order.push_back(0);
    rf_wdata_ready_I = 1'b0;
    wb_idx_I = 5'd12; wb_wdata_I = 32'hC0FFEE00; wb_valid_I = 1'b1;
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (n == 4) rf_wdata_ready_I = 1'b1;
      @(negedge clk);
      if (n == 1) chk("split_c1_valids", {30'd0, rf_idx_valid_O, rf_wdata_valid_O}, 32'd3);
      if (n == 2) chk("split_c2_valids", {30'd0, rf_idx_valid_O, rf_wdata_valid_O}, 32'd1);
      if (wb_done_O) lat = n;
      @(posedge clk); #1;
    end
    wb_valid_I = 1'b0;
    chk("split_latency", lat, 5);
    run_tx(2, 5'd12, 32'hC0FFEE00, 3, "rd2_12");

    // Reset while waiting for read data.
    rdata_hold = 1'b1;
    rd1_idx_I = 5'd12; rd1_valid_I = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("resp_rdata_ready", 32'(rf_rdata_ready_O), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; rd1_valid_I = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; rdata_hold = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {rf_idx_valid_O, rf_wdata_valid_O, rf_rdata_ready_O, rf_idx_op_O,
                         wb_done_O, rd1_data_valid_O, rd2_data_valid_O, rf_idx_O}, 32'd0);
    chk("midrst_rd1_data", rd1_data_O, 32'd0);
    chk("midrst_rd2_data", rd2_data_O, 32'd0);
    chk("midrst_wdata", rf_wdata_O, 32'd0);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (wb_done_O || rd1_data_valid_O || rd2_data_valid_O) cnt++;
    end
    chk("midrst_no_pulse", cnt, 0);
    @(posedge clk); #1;
    run_tx(1, 5'd12, 32'hC0FFEE00, 3, "rd1_after_rst");

    chk("order_drained", exp_order.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
